oflow_score_board_arbiter: RTL and testbench

//  Round-robin arbiter sharing the single score-board write port among PE_NUM registration requesters.

---
 rtl/oflow_arb_pkg.sv | 17 +
 rtl/oflow_rr_picker.sv | 28 ++
 rtl/oflow_score_board_arbiter.sv | 168 ++++++++++++++++
 tb/tb_oflow_score_board_arbiter.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/oflow_arb_pkg.sv
// rtl/oflow_arb_pkg.sv - shared types and defaults for the score-board arbiter
package oflow_arb_pkg;

  localparam int PE_NUM_DEF         = 4;
  localparam int ROW_LEN_DEF        = 6;
  localparam int ID_LEN_DEF         = 12;
  localparam int TIMEOUT_CYCLES_DEF = 255;
  localparam int CNT_LEN_DEF        = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    ACK       = 2'd3
  } arb_state_t;

endpackage

// File: rtl/oflow_rr_picker.sv
// rtl/oflow_rr_picker.sv - combinational round-robin find-first-set starting at i_ptr
module oflow_rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     i_req,
  input  logic [IDX_W-1:0] i_ptr,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_index
);

  logic [IDX_W-1:0] w_pos;

  // Scan from the farthest offset back to i_ptr so the closest set bit is written last.
  always_comb begin
    o_valid = 1'b0;
    o_index = '0;
    w_pos   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      w_pos = IDX_W'((int'(i_ptr) + i) % N);
      if (i_req[w_pos]) begin
        o_valid = 1'b1;
        o_index = w_pos;
      end
    end
  end

endmodule

// File: rtl/oflow_score_board_arbiter.sv
// rtl/oflow_score_board_arbiter.sv - round-robin owner of the score-board write port
module oflow_score_board_arbiter
  import oflow_arb_pkg::*;
#(
  parameter int PE_NUM         = PE_NUM_DEF,
  parameter int ROW_LEN        = ROW_LEN_DEF,
  parameter int ID_LEN         = ID_LEN_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_LEN        = CNT_LEN_DEF
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic                      frame_start,
  input  logic [PE_NUM-1:0]         req,
  input  logic [PE_NUM*ROW_LEN-1:0] req_row_sel,
  input  logic [PE_NUM*ID_LEN-1:0]  req_id,
  output logic [PE_NUM-1:0]         ack,
  output logic [PE_NUM-1:0]         grant,
  output logic                      start_score_board,
  output logic [ROW_LEN-1:0]        row_sel_by_set,
  output logic [ID_LEN-1:0]         id_out,
  input  logic                      done_score_board,
  output logic                      busy,
  output logic                      timeout_err,
  output logic                      spurious_done_err,
  output logic [CNT_LEN-1:0]        grant_cnt
);

  localparam int IDX_W = (PE_NUM > 1) ? $clog2(PE_NUM) : 1;
  localparam int WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WD_W-1:0]  WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(PE_NUM - 1);

  arb_state_t          r_state;
  arb_state_t          w_state_nxt;
  logic [IDX_W-1:0]    r_ptr;
  logic [IDX_W-1:0]    r_idx;
  logic [PE_NUM-1:0]   r_grant;
  logic [PE_NUM-1:0]   r_ack;
  logic                r_start;
  logic [ROW_LEN-1:0]  r_row;
  logic [ID_LEN-1:0]   r_id;
  logic                r_busy;
  logic                r_tmo;
  logic                r_spur;
  logic [CNT_LEN-1:0]  r_cnt;
  logic [WD_W-1:0]     r_wdog;

  logic                w_pick_valid;
  logic [IDX_W-1:0]    w_pick_idx;
  logic [PE_NUM-1:0]   w_pick_onehot;
  logic                w_timeout;
  logic                w_spurious;

  oflow_rr_picker #(
    .N     (PE_NUM),
    .IDX_W (IDX_W)
  ) u_picker (
    .i_req   (req),
    .i_ptr   (r_ptr),
    .o_valid (w_pick_valid),
    .o_index (w_pick_idx)
  );

  assign w_pick_onehot = PE_NUM'(1) << w_pick_idx;

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // frame_start overrides everything, including a done in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    w_spurious  = 1'b0;
    if (frame_start) begin
      w_state_nxt = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_spurious = done_score_board;
          if (w_pick_valid) w_state_nxt = ISSUE;
        end
        ISSUE: begin
          w_state_nxt = done_score_board ? ACK : WAIT_DONE;
        end
        WAIT_DONE: begin
          if (done_score_board) begin
            w_state_nxt = ACK;
          end else if (r_wdog == WD_LAST) begin
            w_timeout   = 1'b1;
            w_state_nxt = ACK;
          end
        end
        ACK: begin
          w_spurious  = done_score_board;
          w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      r_ptr   <= '0;
      r_idx   <= '0;
      r_grant <= '0;
      r_ack   <= '0;
      r_start <= 1'b0;
      r_row   <= '0;
      r_id    <= '0;
      r_busy  <= 1'b0;
      r_tmo   <= 1'b0;
      r_spur  <= 1'b0;
      r_cnt   <= '0;
      r_wdog  <= '0;
    end else begin
      r_busy  <= (w_state_nxt != IDLE);
      r_ack   <= (w_state_nxt == ACK) ? r_grant : '0;
      r_start <= (r_state == ISSUE) && !frame_start;
      if (w_timeout)  r_tmo  <= 1'b1;
      if (w_spurious) r_spur <= 1'b1;
      if (frame_start) begin
        r_ptr   <= '0;
        r_grant <= '0;
        r_cnt   <= '0;
        r_wdog  <= '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_pick_valid) begin
              r_grant <= w_pick_onehot;
              r_idx   <= w_pick_idx;
              r_row   <= req_row_sel[w_pick_idx*ROW_LEN +: ROW_LEN];
              r_id    <= req_id[w_pick_idx*ID_LEN +: ID_LEN];
              if (r_cnt != '1) r_cnt <= r_cnt + CNT_LEN'(1);
            end
          end
          ISSUE: r_wdog <= '0;
          WAIT_DONE: begin
            if (!done_score_board && !w_timeout) r_wdog <= r_wdog + WD_W'(1);
          end
          ACK: begin
            r_ptr   <= (r_idx == PTR_LAST) ? '0 : r_idx + IDX_W'(1);
            r_grant <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  assign ack               = r_ack;
  assign grant             = r_grant;
  assign start_score_board = r_start;
  assign row_sel_by_set    = r_row;
  assign id_out            = r_id;
  assign busy              = r_busy;
  assign timeout_err       = r_tmo;
  assign spurious_done_err = r_spur;
  assign grant_cnt         = r_cnt;

endmodule

// File: tb/tb_oflow_score_board_arbiter.sv
// tb/tb_oflow_score_board_arbiter.sv - directed and randomized bench with a transaction-level model
module tb_oflow_score_board_arbiter;

  localparam int N   = 4;
  localparam int RL  = 6;
  localparam int IL  = 12;
  localparam int TMO = 8;
  localparam int CL  = 3;

  logic            clk = 1'b0;
  logic            reset_N;
  logic            frame_start;
  logic            done;
  logic [N-1:0]    req;
  logic [N*RL-1:0] rows;
  logic [N*IL-1:0] ids;
  logic [N-1:0]    ack;
  logic [N-1:0]    grant;
  logic            start;
  logic [RL-1:0]   row_o;
  logic [IL-1:0]   id_o;
  logic            busy;
  logic            tmo;
  logic            spur;
  logic [CL-1:0]   cnt;

  int   checks   = 0;
  int   failures = 0;
  int   m_ptr;
  int   m_cnt;
  logic m_tmo;
  logic m_spur;
  int   k;
  int   last_k;

  always #5 clk = ~clk;

  oflow_score_board_arbiter #(
    .PE_NUM(N), .ROW_LEN(RL), .ID_LEN(IL), .TIMEOUT_CYCLES(TMO), .CNT_LEN(CL)
  ) dut (
    .clk(clk), .reset_N(reset_N), .frame_start(frame_start),
    .req(req), .req_row_sel(rows), .req_id(ids),
    .ack(ack), .grant(grant), .start_score_board(start),
    .row_sel_by_set(row_o), .id_out(id_o), .done_score_board(done),
    .busy(busy), .timeout_err(tmo), .spurious_done_err(spur), .grant_cnt(cnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Winner is the requester with the smallest forward distance from the pointer.
  function automatic int model_pick(input logic [N-1:0] r, input int p);
    int best;
    int bestd;
    int d;
    best  = -1;
    bestd = N;
    for (int j = 0; j < N; j++) begin
      if (r[j]) begin
        d = (j - p + N) % N;
        if (d < bestd) begin
          bestd = d;
          best  = j;
        end
      end
    end
    return best;
  endfunction

  function automatic int sat_inc(input int c);
    return (c < (1 << CL) - 1) ? c + 1 : c;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "/idle_grant"}, grant, 0);
    check({tag, "/idle_busy"}, busy, 0);
    check({tag, "/idle_ack"}, ack, 0);
    check({tag, "/idle_start"}, start, 0);
    check({tag, "/idle_cnt"}, cnt, m_cnt);
    check({tag, "/idle_tmo"}, tmo, m_tmo);
    check({tag, "/idle_spur"}, spur, m_spur);
  endtask

  task automatic randomize_lanes();
    for (int j = 0; j < N; j++) begin
      rows[j*RL +: RL] = RL'($urandom);
      ids[j*IL +: IL]  = IL'($urandom);
    end
  endtask

  // Called at the negedge of an IDLE cycle with req already driven; delay 0 = done during ISSUE.
  task automatic do_txn(input int delay, input string tag, output int kw);
    int starts;
    logic [RL-1:0] erow;
    logic [IL-1:0] eid;
    kw   = model_pick(req, m_ptr);
    erow = rows[kw*RL +: RL];
    eid  = ids[kw*IL +: IL];
    tick();
    m_cnt = sat_inc(m_cnt);
    check({tag, "/grant"}, grant, 64'(1) << kw);
    check({tag, "/busy"}, busy, 1);
    check({tag, "/row"}, row_o, erow);
    check({tag, "/id"}, id_o, eid);
    check({tag, "/cnt"}, cnt, m_cnt);
    starts = int'(start);
    if (delay == 0) begin
      done = 1'b1;
      tick();
      done = 1'b0;
      starts += int'(start);
    end else begin
      tick();
      check({tag, "/start"}, start, 1);
      starts += int'(start);
      for (int i = 0; i < delay; i++) begin
        tick();
        starts += int'(start);
        check({tag, "/wait_ack"}, ack, 0);
        check({tag, "/hold_grant"}, grant, 64'(1) << kw);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    check({tag, "/ack"}, ack, 64'(1) << kw);
    check({tag, "/ack_grant"}, grant, 64'(1) << kw);
    check({tag, "/ack_row"}, row_o, erow);
    check({tag, "/ack_id"}, id_o, eid);
    req[kw] = 1'b0;
    m_ptr   = (kw + 1) % N;
    tick();
    starts += int'(start);
    check({tag, "/start_count"}, starts, 1);
    check_idle(tag);
  endtask

  initial begin
    reset_N     = 1'b0;
    frame_start = 1'b0;
    done        = 1'b0;
    req         = '0;
    rows        = '0;
    ids         = '0;
    m_ptr = 0; m_cnt = 0; m_tmo = 1'b0; m_spur = 1'b0;
    tick();
    tick();
    check_idle("reset");
    reset_N = 1'b1;
    tick();

    // single requester
    randomize_lanes();
    rows[1*RL +: RL] = RL'(5);
    ids[1*IL +: IL]  = IL'(17);
    req = 4'b0010;
    do_txn(3, "single", k);
    check("single/pe", k, 1);

    // flush coinciding with done: no spurious flag
    frame_start = 1'b1;
    done        = 1'b1;
    tick();
    frame_start = 1'b0;
    done        = 1'b0;
    m_ptr = 0; m_cnt = 0;
    check_idle("flush_done");

    // full contention, strict rotation
    randomize_lanes();
    req = 4'b1111;
    for (int n = 0; n < 4; n++) begin
      do_txn(1 + n, "contend", k);
      check("contend/order", k, n);
    end
    req = 4'b0001;
    do_txn(2, "contend5", k);
    check("contend5/pe", k, 0);

    // done during ISSUE
    randomize_lanes();
    req = 4'b0100;
    do_txn(0, "done_issue", k);

    // watchdog timeout
    randomize_lanes();
    req = 4'b1000;
    k = model_pick(req, m_ptr);
    tick();
    m_cnt = sat_inc(m_cnt);
    check("tmo/grant", grant, 64'(1) << k);
    tick();
    check("tmo/start", start, 1);
    for (int i = 0; i < TMO - 1; i++) begin
      tick();
      check("tmo/early_err", tmo, 0);
      check("tmo/early_ack", ack, 0);
    end
    tick();
    m_tmo = 1'b1;
    check("tmo/err", tmo, 1);
    check("tmo/ack", ack, 64'(1) << k);
    req[k] = 1'b0;
    m_ptr  = (k + 1) % N;
    tick();
    check_idle("tmo");
    req = 4'b0001;
    do_txn(1, "after_tmo", k);
    check("after_tmo/pe", k, 0);

    // flush mid WAIT_DONE, then a late done
    randomize_lanes();
    req = 4'b0100;
    tick();
    m_cnt = sat_inc(m_cnt);
    tick();
    tick();
    frame_start = 1'b1;
    req = '0;
    tick();
    frame_start = 1'b0;
    m_ptr = 0; m_cnt = 0;
    check_idle("flush");
    tick();
    check("flush/no_ack", ack, 0);
    done = 1'b1;
    tick();
    done = 1'b0;
    m_spur = 1'b1;
    check("flush/spur", spur, 1);
    check("flush/busy", busy, 0);
    req = 4'b0010;
    do_txn(1, "after_flush", k);
    check("after_flush/pe", k, 1);

    // randomized traffic, counter saturates
    last_k = k;
    for (int n = 0; n < 20; n++) begin
      randomize_lanes();
      req = N'($urandom) & ~(N'(1) << last_k);
      if (req == '0) req = N'(1) << ((last_k + 1) % N);
      do_txn(int'($urandom_range(0, 5)), "rand", last_k);
    end

    // asynchronous reset in WAIT_DONE
    randomize_lanes();
    req = 4'b0010;
    tick();
    tick();
    tick();
    #2;
    reset_N = 1'b0;
    #1;
    m_ptr = 0; m_cnt = 0; m_tmo = 1'b0; m_spur = 1'b0;
    check_idle("async_rst");
    check("async_rst/row", row_o, 0);
    check("async_rst/id", id_o, 0);
    @(negedge clk);
    reset_N = 1'b1;
    req = 4'b0100;
    do_txn(2, "after_rst", k);
    check("after_rst/pe", k, 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
